// File: rtl/move_flip_scheduler.sv
// move_flip_scheduler: evaluates one candidate Othello move by sweeping the
// 8 directions through a shared calculate_flip instance and accumulating
// the per-direction flip counts into a total, a direction mask and a
// legality flag.
// Optional feature macro: SKIP_PRESCREEN_EN -- skips directions whose
// immediate neighbour cannot start a flip line (off-board, empty or own).
module move_flip_scheduler #(
  parameter int unsigned NDIR  = 8,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned TOT_W = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [2:0]             i_row,
  input  logic [2:0]             i_col,
  input  logic                   i_color,
  input  logic [7:0][7:0][1:0]   i_board,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_legal,
  output logic [TOT_W-1:0]       o_total,
  output logic [NDIR-1:0]        o_dir_mask,
  output logic                   o_cal_start,
  output logic signed [3:0]      o_cal_dir_row,
  output logic signed [3:0]      o_cal_dir_col,
  output logic [2:0]             o_cal_row,
  output logic [2:0]             o_cal_col,
  output logic                   o_cal_color,
  input  logic                   i_cal_done,
  input  logic [CNT_W-1:0]       i_cal_num
);

  localparam int unsigned    D_W    = $clog2(NDIR);
  localparam int unsigned    SUM_W  = TOT_W + 1;
  localparam logic [1:0]     EMPTY  = 2'd2;
  localparam logic [D_W-1:0] LAST_D = D_W'(NDIR - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [D_W-1:0]    d_q, d_d;
  logic [TOT_W-1:0]  tot_q, tot_d;
  logic [NDIR-1:0]   mask_q, mask_d;
  logic [2:0]        row_d, col_d;
  logic              color_d;
  logic              busy_d, done_d, legal_d, cal_start_d;
  logic [TOT_W-1:0]  total_out_d;
  logic [NDIR-1:0]   mask_out_d;
  logic signed [3:0] dir_row_d, dir_col_d;
  logic              skip_cur, skip_nxt;
  logic              step;
  logic [CNT_W-1:0]  step_num;
  logic [SUM_W-1:0]  sum;

  // Row step of direction d in the fixed sweep order
  function automatic logic signed [3:0] dir_row(input logic [D_W-1:0] d);
    case (d)
      D_W'(0), D_W'(1), D_W'(2): dir_row = -4'sd1;
      D_W'(3), D_W'(4):          dir_row = 4'sd0;
      default:                   dir_row = 4'sd1;
    endcase
  endfunction

  // Column step of direction d in the fixed sweep order
  function automatic logic signed [3:0] dir_col(input logic [D_W-1:0] d);
    case (d)
      D_W'(0), D_W'(3), D_W'(5): dir_col = -4'sd1;
      D_W'(1), D_W'(6):          dir_col = 4'sd0;
      default:                   dir_col = 4'sd1;
    endcase
  endfunction

`ifdef SKIP_PRESCREEN_EN
  // A direction cannot flip unless its first neighbour is an opponent disc
  function automatic logic no_flip_start(input logic [D_W-1:0] d);
    logic signed [3:0] dr, dc;
    logic [4:0]        nr, nc;
    logic [1:0]        cell;
    dr = dir_row(d);
    dc = dir_col(d);
    nr = {2'b00, o_cal_row} + {dr[3], dr};
    nc = {2'b00, o_cal_col} + {dc[3], dc};
    cell = i_board[nr[2:0]][nc[2:0]];
    if (nr[4] || nr[3] || nc[4] || nc[3]) no_flip_start = 1'b1;
    else no_flip_start = (cell == EMPTY) || (cell == {1'b0, o_cal_color});
  endfunction

  assign skip_cur = no_flip_start(d_q);
  assign skip_nxt = no_flip_start(d_q + D_W'(1));
`else
  assign skip_cur = 1'b0;
  assign skip_nxt = 1'b0;
`endif

  // Next-state and next-output logic for the direction sweep
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    tot_d       = tot_q;
    mask_d      = mask_q;
    row_d       = o_cal_row;
    col_d       = o_cal_col;
    color_d     = o_cal_color;
    busy_d      = o_busy;
    done_d      = 1'b0;
    legal_d     = o_legal;
    cal_start_d = 1'b0;
    total_out_d = o_total;
    mask_out_d  = o_dir_mask;
    dir_row_d   = o_cal_dir_row;
    dir_col_d   = o_cal_dir_col;
    step        = 1'b0;
    step_num    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_CHECK;
          row_d       = i_row;
          col_d       = i_col;
          color_d     = i_color;
          d_d         = '0;
          tot_d       = '0;
          mask_d      = '0;
          busy_d      = 1'b1;
          legal_d     = 1'b0;
          total_out_d = '0;
          mask_out_d  = '0;
          dir_row_d   = dir_row('0);
          dir_col_d   = dir_col('0);
        end
      end
      S_CHECK: begin
        if (i_board[o_cal_row][o_cal_col] != EMPTY) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d     = S_ISSUE;
          cal_start_d = !skip_cur;
        end
      end
      S_ISSUE: begin
        if (skip_cur) step = 1'b1;
        else          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_cal_done) begin
          step     = 1'b1;
          step_num = i_cal_num;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Fold one direction's result in and move to the next direction
    sum = {1'b0, tot_q} + SUM_W'(step_num);
    if (step) begin
      tot_d       = sum[TOT_W] ? '1 : sum[TOT_W-1:0];
      mask_d[d_q] = (step_num != '0);
      if (d_q == LAST_D) begin
        state_d     = S_FINISH;
        done_d      = 1'b1;
        total_out_d = tot_d;
        mask_out_d  = mask_d;
        legal_d     = (tot_d != '0);
      end else begin
        d_d         = d_q + D_W'(1);
        state_d     = S_ISSUE;
        cal_start_d = !skip_nxt;
        dir_row_d   = dir_row(d_d);
        dir_col_d   = dir_col(d_d);
      end
    end
  end

  // State, accumulator and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      d_q           <= '0;
      tot_q         <= '0;
      mask_q        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_legal       <= 1'b0;
      o_total       <= '0;
      o_dir_mask    <= '0;
      o_cal_start   <= 1'b0;
      o_cal_dir_row <= '0;
      o_cal_dir_col <= '0;
      o_cal_row     <= '0;
      o_cal_col     <= '0;
      o_cal_color   <= 1'b0;
    end else begin
      state_q       <= state_d;
      d_q           <= d_d;
      tot_q         <= tot_d;
      mask_q        <= mask_d;
      o_busy        <= busy_d;
      o_done        <= done_d;
      o_legal       <= legal_d;
      o_total       <= total_out_d;
      o_dir_mask    <= mask_out_d;
      o_cal_start   <= cal_start_d;
      o_cal_dir_row <= dir_row_d;
      o_cal_dir_col <= dir_col_d;
      o_cal_row     <= row_d;
      o_cal_col     <= col_d;
      o_cal_color   <= color_d;
    end
  end

endmodule
